// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Line-fill / write-back arbiter between the I stage (line reads) and the
// D stage (line reads and evictions) and one fixed-latency memory port.
// Exactly one requester owns the memory port at a time. The owner receives
// its line in a register and a one-cycle ack pulse when the access is done.
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous, active-low reset
//   i_req      I-side read request, held until i_ack
//   i_addr     I-side byte address
//   i_ack      one-cycle pulse, i_line valid
//   i_line     I-side returned line (registered)
//   d_req      D-side request, held until d_ack
//   d_we       D-side write enable (1 = write d_wline)
//   d_addr     D-side byte address
//   d_wline    D-side write line
//   d_ack      one-cycle pulse, D access complete
//   d_rline    D-side returned line (registered)
//   mem_req    high for LATENCY cycles per access
//   mem_we     memory write enable
//   mem_addr   line-aligned memory address
//   mem_wline  memory write data
//   mem_rline  memory read data, sampled on the last mem_req cycle
//   mem_busy   high whenever an access is in flight
//
// Configuration macro
//   MEM_ARBITER_RR_EN  defined: round-robin on simultaneous requests
//                      undefined: fixed priority, D wins ties
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDRESS_SIZE = 32,
    parameter int LINE_SIZE    = 128,
    parameter int LATENCY      = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_req,
    input  logic [ADDRESS_SIZE-1:0] i_addr,
    output logic                    i_ack,
    output logic [LINE_SIZE-1:0]    i_line,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDRESS_SIZE-1:0] d_addr,
    input  logic [LINE_SIZE-1:0]    d_wline,
    output logic                    d_ack,
    output logic [LINE_SIZE-1:0]    d_rline,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDRESS_SIZE-1:0] mem_addr,
    output logic [LINE_SIZE-1:0]    mem_wline,
    input  logic [LINE_SIZE-1:0]    mem_rline,
    output logic                    mem_busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int OFFSET_BITS = $clog2(LINE_SIZE / 8);
    localparam int CNT_W       = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [ADDRESS_SIZE-1:0] ALIGN_MASK = {ADDRESS_SIZE{1'b1}} << OFFSET_BITS;
    localparam logic [CNT_W-1:0]        CNT_LOAD   = CNT_W'(LATENCY - 1);

    logic [1:0]              r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_ownerD;
    logic [ADDRESS_SIZE-1:0] r_addr;
    logic                    r_we;
    logic [LINE_SIZE-1:0]    r_wline;
    logic [LINE_SIZE-1:0]    r_iLine;
    logic [LINE_SIZE-1:0]    r_dLine;

    logic                    w_grantD;
    logic                    w_inWait;

    // Grant decision in IDLE. r_ownerD doubles as "last side granted", so in
    // round-robin mode I wins a tie when D was served last (including the
    // first tie after reset, since the owner resets to D).
`ifdef MEM_ARBITER_RR_EN
    assign w_grantD = d_req & (~i_req | ~r_ownerD);
`else
    assign w_grantD = d_req;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_ownerD <= 1'b1;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_wline  <= '0;
            r_iLine  <= '0;
            r_dLine  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req || d_req) begin
                        r_ownerD <= w_grantD;
                        r_addr   <= (w_grantD ? d_addr : i_addr) & ALIGN_MASK;
                        r_we     <= w_grantD & d_we;
                        r_wline  <= w_grantD ? d_wline : '0;
                        r_cnt    <= CNT_LOAD;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        // Writes leave both line registers untouched.
                        if (!r_we) begin
                            if (r_ownerD) begin
                                r_dLine <= mem_rline;
                            end else begin
                                r_iLine <= mem_rline;
                            end
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Memory-side outputs are decoded from state so an asynchronous reset
    // drops them immediately; data fields are zero outside an access.
    assign w_inWait  = (r_state == S_WAIT);
    assign mem_req   = w_inWait;
    assign mem_we    = w_inWait & r_we;
    assign mem_addr  = w_inWait ? r_addr : '0;
    assign mem_wline = w_inWait ? r_wline : '0;
    assign mem_busy  = (r_state != S_IDLE);

    assign i_ack   = (r_state == S_DONE) & ~r_ownerD;
    assign d_ack   = (r_state == S_DONE) &  r_ownerD;
    assign i_line  = r_iLine;
    assign d_rline = r_dLine;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Randomized self-checking bench for mem_arbiter. A transaction-level model
// tracks the single in-flight access by its grant cycle and derives every
// expected output from cycle arithmetic relative to that grant.
// The memory model returns the line address replicated, with the lowest word
// xor'ed with the current cycle number so the capture cycle is visible.
// Honors MEM_ARBITER_RR_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int LW  = 128;
    localparam int LAT = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_ack;
    logic [LW-1:0] i_line;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [LW-1:0] d_wline = '0;
    logic          d_ack;
    logic [LW-1:0] d_rline;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wline;
    logic [LW-1:0] mem_rline;
    logic          mem_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model of the one in-flight access plus the expected line registers.
    bit            mActive = 1'b0;
    int            mStart = 0;
    int            mFreeFrom = 0;
    bit            mOwnerD = 1'b0;
    bit            mWe = 1'b0;
    logic [AW-1:0] mAddr = '0;
    logic [LW-1:0] mWline = '0;
    bit            lastD = 1'b1;
    bit            inReset = 1'b1;
    logic [LW-1:0] expILine = '0;
    logic [LW-1:0] expDLine = '0;

    // Requester agents: pending until acked, granted once the model grants.
    bit iPend = 1'b0;
    bit iGranted = 1'b0;
    bit dPend = 1'b0;
    bit dGranted = 1'b0;

    mem_arbiter #(.ADDRESS_SIZE(AW), .LINE_SIZE(LW), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_line(i_line),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wline(d_wline),
        .d_ack(d_ack), .d_rline(d_rline),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wline(mem_wline), .mem_rline(mem_rline), .mem_busy(mem_busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter; during cycle c the value read at the falling edge is c.
    always @(posedge clk) cyc <= cyc + 1;

    // Memory returns the addressed line tagged with the sampling cycle.
    assign mem_rline = {mem_addr, mem_addr, mem_addr, mem_addr ^ 32'(cyc)};

    function automatic logic [LW-1:0] lineFor(input logic [AW-1:0] a, input int c);
        return {a, a, a, a ^ 32'(c)};
    endfunction

    task automatic checkOutput(input string tag, input logic [LW-1:0] observed,
                               input logic [LW-1:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Compare every output against the model for the current cycle.
    task automatic checkCycle();
        bit inWait;
        bit inDone;
        inWait = mActive && (cyc >= mStart + 1) && (cyc <= mStart + LAT);
        inDone = mActive && (cyc == mStart + LAT + 1);
        if (inDone && !mWe) begin
            if (mOwnerD) expDLine = lineFor(mAddr, mStart + LAT);
            else         expILine = lineFor(mAddr, mStart + LAT);
        end
        checkOutput("mem_req", LW'(mem_req), LW'(inWait));
        checkOutput("mem_busy", LW'(mem_busy), LW'(inWait || inDone));
        checkOutput("i_ack", LW'(i_ack), LW'(inDone && !mOwnerD));
        checkOutput("d_ack", LW'(d_ack), LW'(inDone && mOwnerD));
        checkOutput("i_line", i_line, expILine);
        checkOutput("d_rline", d_rline, expDLine);
        if (inWait) begin
            checkOutput("mem_we", LW'(mem_we), LW'(mWe));
            checkOutput("mem_addr", LW'(mem_addr), LW'(mAddr));
            if (mWe) checkOutput("mem_wline", mem_wline, mWline);
        end
        if (inDone) begin
            mActive = 1'b0;
            if (mOwnerD) begin
                dPend = 1'b0;
                dGranted = 1'b0;
            end else begin
                iPend = 1'b0;
                iGranted = 1'b0;
            end
        end
    endtask

    // Drive requester inputs; a granted requester scrambles its fields to
    // show they are ignored once the access has started.
    task automatic applyStimulus(input int reqPct);
        if (!iPend && !inReset && ($urandom_range(99) < reqPct)) begin
            iPend  = 1'b1;
            i_addr = $urandom;
        end else if (iGranted) begin
            i_addr = $urandom;
        end
        if (!dPend && !inReset && ($urandom_range(99) < reqPct)) begin
            dPend   = 1'b1;
            d_addr  = $urandom;
            d_we    = 1'($urandom_range(1));
            d_wline = {$urandom, $urandom, $urandom, $urandom};
        end else if (dGranted) begin
            d_addr  = $urandom;
            d_we    = ~d_we;
            d_wline = {$urandom, $urandom, $urandom, $urandom};
        end
        i_req = iPend;
        d_req = dPend;
    endtask

    // Model grant for the requests that the coming rising edge samples.
    task automatic modelGrant();
        bit winD;
        logic [AW-1:0] a;
        if (inReset || mActive || cyc < mFreeFrom || !(i_req || d_req)) return;
        if (i_req && d_req) begin
`ifdef MEM_ARBITER_RR_EN
            winD = !lastD;
`else
            winD = 1'b1;
`endif
        end else begin
            winD = d_req;
        end
        a         = winD ? d_addr : i_addr;
        mAddr     = a - (a % AW'(LW / 8));
        mOwnerD   = winD;
        lastD     = winD;
        mWe       = winD && d_we;
        mWline    = d_wline;
        mStart    = cyc;
        mFreeFrom = cyc + LAT + 2;
        mActive   = 1'b1;
        if (winD) dGranted = 1'b1;
        else      iGranted = 1'b1;
    endtask

    task automatic stepCycle(input int reqPct);
        @(negedge clk);
        checkCycle();
        applyStimulus(reqPct);
        modelGrant();
    endtask

    task automatic clearModel();
        mActive   = 1'b0;
        mFreeFrom = 0;
        lastD     = 1'b1;
        expILine  = '0;
        expDLine  = '0;
        iPend     = 1'b0;
        iGranted  = 1'b0;
        dPend     = 1'b0;
        dGranted  = 1'b0;
    endtask

    // Main sequence: reset checks, random traffic at several densities,
    // a reset in the middle of an access, then more traffic.
    initial begin
        bit hit;
        inReset = 1'b1;
        clearModel();
        for (int k = 0; k < 3; k++) stepCycle(0);
        @(negedge clk);
        reset   = 1'b1;
        inReset = 1'b0;

        for (int k = 0; k < 300; k++) stepCycle(30);
        for (int k = 0; k < 300; k++) stepCycle(100);
        for (int k = 0; k < 200; k++) stepCycle(5);

        hit = 1'b0;
        for (int k = 0; k < 60 && !hit; k++) begin
            stepCycle(60);
            if (mActive && cyc == mStart + 3) hit = 1'b1;
        end
        checkOutput("mid_access_reached", LW'(hit), LW'(1'b1));
        if (hit) begin
            @(posedge clk);
            #2;
            reset   = 1'b0;
            inReset = 1'b1;
            i_req   = 1'b0;
            d_req   = 1'b0;
            clearModel();
            #1;
            checkOutput("rst_mem_req", LW'(mem_req), '0);
            checkOutput("rst_mem_busy", LW'(mem_busy), '0);
            checkOutput("rst_i_ack", LW'(i_ack), '0);
            checkOutput("rst_d_ack", LW'(d_ack), '0);
            checkOutput("rst_i_line", i_line, '0);
            checkOutput("rst_d_rline", d_rline, '0);
            for (int k = 0; k < 3; k++) stepCycle(0);
            @(negedge clk);
            reset   = 1'b1;
            inReset = 1'b0;
        end

        for (int k = 0; k < 300; k++) stepCycle(100);
        for (int k = 0; k < 300; k++) stepCycle(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
